exe_arbiter: RTL
================

EXE_ARBITER -- requirements
Module: exe_arbiter

Interface
REQ-001 Parameter m, default 4: operand/result width in bits; SHALL match the shared execution unit.
REQ-002 Parameter n, default 2: operation-code width in bits.
REQ-003 Parameter LAT, default 1: execution-unit latency in clock cycles, legal range 1..7.
REQ-004 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_rsn  in  1  reset, asynchronous and active-low.
REQ-006 i_req0_valid, i_req1_valid  in  1  request pending from requester 0 / 1.
REQ-007 i_req0_oper, i_req1_oper  in  n  requested operation code.
REQ-008 i_req0_argA, i_req0_argB, i_req1_argA, i_req1_argB  in  m  signed operands.
REQ-009 o_req0_ready, o_req1_ready  out  1  single-cycle accept pulse to the granted requester.
REQ-010 o_exe_oper  out  n, o_exe_argA / o_exe_argB  out  m  registered drive to the execution unit.
REQ-011 i_exe_result  in  m, i_exe_status  in  2  execution-unit outputs.
REQ-012 o_rsp_valid  out  1, i_rsp_ready  in  1  shared response handshake.
REQ-013 o_rsp_id  out  1, o_rsp_result  out  m, o_rsp_status  out  2  response payload; o_rsp_id names the originating requester.

Function
REQ-014 The FSM SHALL have four states (IDLE, ISSUE, WAIT, RESP) and exactly one operation in flight at a time.
REQ-015 IDLE, no i_reqX_valid asserted: the FSM SHALL remain in IDLE.
REQ-016 IDLE, cycle T, any i_reqX_valid asserted:
  - the arbiter SHALL grant one requester;
  - it SHALL pulse that requester's o_reqX_ready high during T only;
  - it SHALL register oper/argA/argB and the grant id at the end of T;
  - the FSM SHALL enter ISSUE.
REQ-017 ISSUE, cycle T+1: o_exe_* SHALL carry the captured operands; the FSM SHALL enter WAIT with its latency counter loaded to LAT.
REQ-018 WAIT: o_exe_* SHALL stay unchanged and the counter SHALL decrement each cycle.
REQ-019 WAIT, counter==1 (cycle T+1+LAT): i_exe_result and i_exe_status SHALL be captured; the FSM SHALL enter RESP.
REQ-020 RESP:
  - o_rsp_valid SHALL be 1, with id, result and status held stable until the cycle in which i_rsp_ready==1;
  - the FSM SHALL return to IDLE after that cycle.
REQ-021 A new grant SHALL NOT occur in the cycle in which RESP completes; the earliest next accept is the following IDLE cycle.
REQ-022 o_reqX_ready SHALL be 0 in every state other than IDLE.
REQ-023 A requester that drops valid before it is granted SHALL NOT be granted.
REQ-024 Operands SHALL pass through unmodified; no width conversion is applied (m in, m out).

Reset
REQ-025 While i_rsn==0, asynchronously and regardless of state:
  - state SHALL be IDLE;
  - every output SHALL be 0;
  - the latency counter and captured registers SHALL be 0;
  - the round-robin pointer SHALL select requester 0.
REQ-026 A reset during ISSUE, WAIT or RESP SHALL discard the in-flight operation without issuing a response; the requester SHALL resend.

Configuration
REQ-027 Macro EXE_ARBITER_RR_EN defined: when both requesters are valid, grant SHALL be round-robin, and the pointer SHALL move to the non-granted requester after each grant.
REQ-028 EXE_ARBITER_RR_EN undefined: grant SHALL be fixed priority, with requester 0 always winning a tie.
REQ-029 In both modes a lone valid requester SHALL be granted immediately.

Structure
REQ-030 Shared package exe_pkg SHALL hold:
  - the FSM state enum;
  - the requester-id typedef;
  - the operation-code constants shared with the execution unit.
REQ-031 Grant selection and the pointer SHALL live in sub-module rr_arbiter2; the pointer SHALL be tied off when EXE_ARBITER_RR_EN is undefined.

Verification (m=4, n=2, LAT=1 unless stated)
REQ-032 Reset: assert i_rsn=0 mid-run -> all outputs 0 immediately; after release, the first grant with both requesters valid goes to id 0.
REQ-033 Single request: req0 oper=2'b11, argA=4'd5, argB=4'd2, bench exe model returns result 4'd1 / status 2'b00 ->
  - o_req0_ready pulses in T;
  - o_exe_oper=3 and o_exe_argA=5 from T+1;
  - o_rsp_valid=1 at T+3 with id 0, result 1, status 0.
REQ-034 Both requesters valid for 3 operations -> grant order 0,1,0 with EXE_ARBITER_RR_EN; 0,0,0 without it.
REQ-035 Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> payload stable, both ready outputs 0; accept occurs the cycle after i_rsp_ready=1.
REQ-036 LAT=3: request accepted at T -> capture at T+4, o_rsp_valid at T+5.
REQ-037 Reset asserted during WAIT -> no o_rsp_valid; after release, the resent request completes normally.

Source files
------------

// File: rtl/exe_pkg.sv
// Types and constants shared by the execution-unit arbiter and the execution unit.
package exe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef logic req_id_t;

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_SRA = 2'd3;

endpackage

// File: rtl/exe_arbiter_if.sv
// Requester, execution-unit and response signals of exe_arbiter; slave is the arbiter side.
interface exe_arbiter_if #(
  parameter int unsigned m = 4,
  parameter int unsigned n = 2
);
  logic         i_req0_valid;
  logic         i_req1_valid;
  logic [n-1:0] i_req0_oper;
  logic [n-1:0] i_req1_oper;
  logic [m-1:0] i_req0_argA;
  logic [m-1:0] i_req0_argB;
  logic [m-1:0] i_req1_argA;
  logic [m-1:0] i_req1_argB;
  logic         o_req0_ready;
  logic         o_req1_ready;
  logic [n-1:0] o_exe_oper;
  logic [m-1:0] o_exe_argA;
  logic [m-1:0] o_exe_argB;
  logic [m-1:0] i_exe_result;
  logic [1:0]   i_exe_status;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic         o_rsp_id;
  logic [m-1:0] o_rsp_result;
  logic [1:0]   o_rsp_status;

  modport slave (
    input  i_req0_valid, i_req1_valid, i_req0_oper, i_req1_oper,
           i_req0_argA, i_req0_argB, i_req1_argA, i_req1_argB,
           i_exe_result, i_exe_status, i_rsp_ready,
    output o_req0_ready, o_req1_ready, o_exe_oper, o_exe_argA, o_exe_argB,
           o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status
  );

  modport master (
    output i_req0_valid, i_req1_valid, i_req0_oper, i_req1_oper,
           i_req0_argA, i_req0_argB, i_req1_argA, i_req1_argB,
           i_exe_result, i_exe_status, i_rsp_ready,
    input  o_req0_ready, o_req1_ready, o_exe_oper, o_exe_argA, o_exe_argB,
           o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant selection. EXE_ARBITER_RR_EN: round-robin on ties; otherwise requester 0 wins.
module rr_arbiter2
  import exe_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rsn,
  input  logic    i_valid0,
  input  logic    i_valid1,
  input  logic    i_take,
  output logic    o_gnt_vld,
  output req_id_t o_gnt_id
);

  req_id_t ptr_q;

`ifdef EXE_ARBITER_RR_EN
  // Pointer favours whoever lost the most recent grant.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn)      ptr_q <= 1'b0;
    else if (i_take) ptr_q <= ~o_gnt_id;
  end
`else
  logic unused_take;
  assign unused_take = i_take;

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) ptr_q <= 1'b0;
    else        ptr_q <= 1'b0;
  end
`endif

  always_comb begin
    o_gnt_vld = i_valid0 | i_valid1;
    o_gnt_id  = 1'b0;
    if (i_valid0 && i_valid1) o_gnt_id = ptr_q;
    else if (i_valid1)        o_gnt_id = 1'b1;
  end

endmodule

// File: rtl/exe_arbiter.sv
// Shares one execution unit between two requesters, one operation in flight.
// Optional macro EXE_ARBITER_RR_EN selects round-robin instead of fixed priority.
module exe_arbiter
  import exe_pkg::*;
#(
  parameter int unsigned m   = 4,
  parameter int unsigned n   = 2,
  parameter int unsigned LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  exe_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [n-1:0]     oper_q;
  logic [m-1:0]     arga_q, argb_q, result_q;
  logic [1:0]       status_q;
  req_id_t          id_q;
  logic             gnt_vld;
  req_id_t          gnt_id;
  logic             take;

  assign take = (state_q == ST_IDLE) && gnt_vld;

  rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_rsn    (i_rsn),
    .i_valid0 (bus.i_req0_valid),
    .i_valid1 (bus.i_req1_valid),
    .i_take   (take),
    .o_gnt_vld(gnt_vld),
    .o_gnt_id (gnt_id)
  );

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_vld) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      ST_RESP:  if (bus.i_rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Accept pulse is combinational so it lands in the grant cycle; gated while in reset.
  always_comb begin
    bus.o_req0_ready = 1'b0;
    bus.o_req1_ready = 1'b0;
    bus.o_rsp_valid  = 1'b0;
    if (i_rsn) begin
      case (state_q)
        ST_IDLE: begin
          bus.o_req0_ready = gnt_vld && !gnt_id;
          bus.o_req1_ready = gnt_vld && gnt_id;
        end
        ST_RESP: bus.o_rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand capture doubles as the execution-unit drive; result captured on the last wait cycle.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      cnt_q    <= '0;
      oper_q   <= '0;
      arga_q   <= '0;
      argb_q   <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (take) begin
          id_q   <= gnt_id;
          oper_q <= gnt_id ? bus.i_req1_oper : bus.i_req0_oper;
          arga_q <= gnt_id ? bus.i_req1_argA : bus.i_req0_argA;
          argb_q <= gnt_id ? bus.i_req1_argB : bus.i_req0_argB;
        end
        ST_ISSUE: cnt_q <= CNT_W'(LAT);
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= bus.i_exe_result;
            status_q <= bus.i_exe_status;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_exe_oper   = oper_q;
  assign bus.o_exe_argA   = arga_q;
  assign bus.o_exe_argB   = argb_q;
  assign bus.o_rsp_id     = id_q;
  assign bus.o_rsp_result = result_q;
  assign bus.o_rsp_status = status_q;

endmodule
